avst_compare_seq: RTL and testbench

- Run-level sequencer for the 128-bit Avalon-ST stream comparator.
- Host programs pass count and timeout over an Avalon-MM CSR slave, then writes start.
- Per pass: pulses a start strobe to the two stream sources, waits for the comparator's end-of-packet error report, classifies the pass, accumulates mismatch bits.
- Raises done/fail status and an optional interrupt.

---
 rtl/avst_compare_seq_pkg.sv | 36 +++
 rtl/avst_compare_seq_csr.sv | 165 ++++++++++++++++
 rtl/avst_compare_seq.sv | 180 ++++++++++++++++++
 tb/tb_avst_compare_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avst_compare_seq_pkg.sv
// Shared types and constants for the avst_compare_seq run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avst_compare_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // CSR word addresses
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_NUM_PASS = 3'd2;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ADDR_PASS_CNT = 3'd4;
  localparam logic [2:0] ADDR_FAIL_CNT = 3'd5;
  localparam logic [2:0] ADDR_ERR_SEL  = 3'd6;
  localparam logic [2:0] ADDR_ERR_WORD = 3'd7;

  // CTRL bit indices
  localparam int CTRL_START        = 0;
  localparam int CTRL_ABORT        = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_STOP_ON_FAIL = 3;

  // STATUS bit indices
  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_FAIL    = 2;
  localparam int STS_TIMEOUT = 3;

endpackage

// File: rtl/avst_compare_seq_csr.sv
// CSR register file for avst_compare_seq: control, W1C status, shadowable config, lane mux.
// Latency: readdata registered, valid one cycle after avs read; start/abort decoded combinationally.
// Backpressure: none; slave accepts every access with zero wait states.
// Ports: Avalon-MM slave (address/write/writedata/read/readdata), control strobes and config to the
// FSM, status set/clear strobes and counters/ERR_ACC from the FSM.
// Optional: AVST_COMPARE_SEQ_STOP_ON_FAIL_EN adds a R/W stop_on_fail bit at CTRL[3].
module avst_compare_seq_csr
  import avst_compare_seq_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 24
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [2:0]        address_i,
  input  logic              write_i,
  input  logic [31:0]       writedata_i,
  input  logic              read_i,
  output logic [31:0]       readdata_o,
  output logic              start_o,
  output logic              abort_o,
  output logic              irq_en_o,
  output logic              stop_on_fail_o,
  output logic [CNT_W-1:0]  num_passes_o,
  output logic [TMO_W-1:0]  timeout_o,
  output logic              done_o,
  output logic              fail_o,
  input  logic              busy_i,
  input  logic              sts_clr_i,
  input  logic              done_set_i,
  input  logic              fail_set_i,
  input  logic              tmo_set_i,
  input  logic [CNT_W-1:0]  pass_cnt_i,
  input  logic [CNT_W-1:0]  fail_cnt_i,
  input  logic [DATA_W-1:0] err_acc_i
);

  localparam int LANES = DATA_W / 32;

  logic              irq_en_q, irq_en_d;
  logic              stop_q, stop_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       err_sel_q, err_sel_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       err_word;
  logic              wr_ctrl;

  assign wr_ctrl        = write_i && (address_i == ADDR_CTRL);
  assign start_o        = wr_ctrl && writedata_i[CTRL_START];
  assign abort_o        = wr_ctrl && writedata_i[CTRL_ABORT];
  assign irq_en_o       = irq_en_q;
  assign stop_on_fail_o = stop_q;
  assign num_passes_o   = num_q;
  assign timeout_o      = tmo_q;
  assign done_o         = done_q;
  assign fail_o         = fail_q;
  assign readdata_o     = rdata_q;

  // Lane mux; any ERR_SEL beyond the last lane falls through to zero.
  always_comb begin
    err_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (err_sel_q == 32'(i)) err_word = err_acc_i[i*32 +: 32];
    end
  end

  always_comb begin
    irq_en_d   = irq_en_q;
`ifdef AVST_COMPARE_SEQ_STOP_ON_FAIL_EN
    stop_d     = stop_q;
`else
    stop_d     = 1'b0;
`endif
    num_d      = num_q;
    tmo_d      = tmo_q;
    err_sel_d  = err_sel_q;
    done_d     = done_q;
    fail_d     = fail_q;
    tmo_flag_d = tmo_flag_q;

    if (write_i) begin
      case (address_i)
        ADDR_CTRL: begin
          irq_en_d = writedata_i[CTRL_IRQ_EN];
`ifdef AVST_COMPARE_SEQ_STOP_ON_FAIL_EN
          stop_d   = writedata_i[CTRL_STOP_ON_FAIL];
`endif
        end
        ADDR_STATUS: begin
          done_d     = done_q     & ~writedata_i[STS_DONE];
          fail_d     = fail_q     & ~writedata_i[STS_FAIL];
          tmo_flag_d = tmo_flag_q & ~writedata_i[STS_TIMEOUT];
        end
        ADDR_NUM_PASS: num_d     = writedata_i[CNT_W-1:0];
        ADDR_TIMEOUT:  tmo_d     = writedata_i[TMO_W-1:0];
        ADDR_ERR_SEL:  err_sel_d = writedata_i;
        default: ;
      endcase
    end

    // Run-start clear, then hardware sets override any coincident W1C.
    if (sts_clr_i) begin
      done_d     = 1'b0;
      fail_d     = 1'b0;
      tmo_flag_d = 1'b0;
    end
    if (done_set_i) done_d     = 1'b1;
    if (fail_set_i) fail_d     = 1'b1;
    if (tmo_set_i)  tmo_flag_d = 1'b1;

    rdata_d = rdata_q;
    if (read_i) begin
      rdata_d = '0;
      case (address_i)
        ADDR_CTRL: begin
          rdata_d[CTRL_IRQ_EN]       = irq_en_q;
          rdata_d[CTRL_STOP_ON_FAIL] = stop_q;
        end
        ADDR_STATUS: begin
          rdata_d[STS_BUSY]    = busy_i;
          rdata_d[STS_DONE]    = done_q;
          rdata_d[STS_FAIL]    = fail_q;
          rdata_d[STS_TIMEOUT] = tmo_flag_q;
        end
        ADDR_NUM_PASS: rdata_d = 32'(num_q);
        ADDR_TIMEOUT:  rdata_d = 32'(tmo_q);
        ADDR_PASS_CNT: rdata_d = 32'(pass_cnt_i);
        ADDR_FAIL_CNT: rdata_d = 32'(fail_cnt_i);
        ADDR_ERR_SEL:  rdata_d = err_sel_q;
        ADDR_ERR_WORD: rdata_d = err_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irq_en_q   <= 1'b0;
      stop_q     <= 1'b0;
      num_q      <= '0;
      tmo_q      <= '0;
      err_sel_q  <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      irq_en_q   <= irq_en_d;
      stop_q     <= stop_d;
      num_q      <= num_d;
      tmo_q      <= tmo_d;
      err_sel_q  <= err_sel_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      tmo_flag_q <= tmo_flag_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: rtl/avst_compare_seq.sv
// Run-level sequencer for the Avalon-ST stream comparator: launches passes, classifies, accumulates.
// Latency: src_start one cycle after start write; src_abort one cycle after abort or timeout detect.
// Backpressure: none; comparator result strobe is accepted only in WAIT, dropped elsewhere.
// Ports: clk/reset (sync, active-high); avs_csr_* Avalon-MM slave; src_start/src_abort pulses to the
// stream sources; cmp_err_valid/cmp_err_data from the comparator; irq = irq_en & (done | fail).
// Optional: AVST_COMPARE_SEQ_STOP_ON_FAIL_EN ends the run at the first failing pass when enabled.
// DATA_W must be a multiple of 32.
module avst_compare_seq
  import avst_compare_seq_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_csr_address,
  input  logic              avs_csr_write,
  input  logic [31:0]       avs_csr_writedata,
  input  logic              avs_csr_read,
  output logic [31:0]       avs_csr_readdata,
  output logic              src_start,
  output logic              src_abort,
  input  logic              cmp_err_valid,
  input  logic [DATA_W-1:0] cmp_err_data,
  output logic              irq
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]  num_sh_q, num_sh_d;
  logic [TMO_W-1:0]  tmo_sh_q, tmo_sh_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] err_acc_q, err_acc_d;
  logic [DATA_W-1:0] err_lat_q, err_lat_d;
  logic              src_abort_q, src_abort_d;

  logic              csr_start, csr_abort, irq_en, stop_on_fail;
  logic [CNT_W-1:0]  csr_num;
  logic [TMO_W-1:0]  csr_tmo;
  logic              sts_done, sts_fail;
  logic              sts_clr, done_set, fail_set, tmo_set;
  logic              busy, lat_fail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign busy      = (state_q != ST_IDLE);
  assign lat_fail  = |err_lat_q;
  assign src_start = (state_q == ST_LAUNCH);
  assign src_abort = src_abort_q;
  assign irq       = irq_en & (sts_done | sts_fail);

  avst_compare_seq_csr #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .TMO_W (TMO_W)
  ) u_csr (
    .clk_i         (clk),
    .reset_i       (reset),
    .address_i     (avs_csr_address),
    .write_i       (avs_csr_write),
    .writedata_i   (avs_csr_writedata),
    .read_i        (avs_csr_read),
    .readdata_o    (avs_csr_readdata),
    .start_o       (csr_start),
    .abort_o       (csr_abort),
    .irq_en_o      (irq_en),
    .stop_on_fail_o(stop_on_fail),
    .num_passes_o  (csr_num),
    .timeout_o     (csr_tmo),
    .done_o        (sts_done),
    .fail_o        (sts_fail),
    .busy_i        (busy),
    .sts_clr_i     (sts_clr),
    .done_set_i    (done_set),
    .fail_set_i    (fail_set),
    .tmo_set_i     (tmo_set),
    .pass_cnt_i    (pass_cnt_q),
    .fail_cnt_i    (fail_cnt_q),
    .err_acc_i     (err_acc_q)
  );

  always_comb begin
    state_d     = state_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    num_sh_d    = num_sh_q;
    tmo_sh_d    = tmo_sh_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_acc_d   = err_acc_q;
    err_lat_d   = err_lat_q;
    src_abort_d = 1'b0;
    sts_clr     = 1'b0;
    done_set    = 1'b0;
    fail_set    = 1'b0;
    tmo_set     = 1'b0;

    if (csr_abort && busy) begin
      // Abort overrides whatever the current state would have done; counters hold.
      src_abort_d = 1'b1;
      state_d     = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csr_start) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_acc_d  = '0;
            sts_clr    = 1'b1;
            num_sh_d   = csr_num;
            tmo_sh_d   = csr_tmo;
            state_d    = (csr_num == '0) ? ST_DONE : ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (cmp_err_valid) begin
            err_lat_d = cmp_err_data;
            state_d   = ST_CHECK;
          end else if ((tmo_sh_q != '0) && (tmo_cnt_d == tmo_sh_q)) begin
            tmo_set     = 1'b1;
            fail_set    = 1'b1;
            fail_cnt_d  = sat_inc(fail_cnt_q);
            src_abort_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        ST_CHECK: begin
          if (lat_fail) fail_cnt_d = sat_inc(fail_cnt_q);
          else          pass_cnt_d = sat_inc(pass_cnt_q);
          err_acc_d = err_acc_q | err_lat_q;
          // Compare with one extra bit so the sum cannot wrap.
          if ((({1'b0, pass_cnt_d} + {1'b0, fail_cnt_d}) == {1'b0, num_sh_q}) ||
              (stop_on_fail && lat_fail))
            state_d = ST_DONE;
          else
            state_d = ST_LAUNCH;
        end
        ST_DONE: begin
          done_set = 1'b1;
          fail_set = (fail_cnt_q != '0);
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      num_sh_q    <= '0;
      tmo_sh_q    <= '0;
      tmo_cnt_q   <= '0;
      err_acc_q   <= '0;
      err_lat_q   <= '0;
      src_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      num_sh_q    <= num_sh_d;
      tmo_sh_q    <= tmo_sh_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_acc_q   <= err_acc_d;
      err_lat_q   <= err_lat_d;
      src_abort_q <= src_abort_d;
    end
  end

endmodule

// File: tb/tb_avst_compare_seq.sv
module tb_avst_compare_seq;

  localparam int DW = 128;
  localparam logic [2:0] A_CTRL = 3'd0, A_STS = 3'd1, A_NUM = 3'd2, A_TMO = 3'd3;
  localparam logic [2:0] A_PASS = 3'd4, A_FAIL = 3'd5, A_SEL = 3'd6, A_WORD = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    addr;
  logic          wr, rd;
  logic [31:0]   wdata, rdata;
  logic          src_start, src_abort, cmp_err_valid, irq;
  logic [DW-1:0] cmp_err_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, n_start = 0, n_abort = 0;

  logic [DW-1:0] vec_arr [8];
  int            dly_arr [8];

  typedef struct {
    int          n;
    logic [7:0]  fmask;
    int          bidx;
    int          exp_pass;
    int          exp_fail;
    logic [31:0] exp_sts;
    int          lane;
    logic [31:0] exp_word;
  } tvec_t;
  tvec_t tv [5];

  avst_compare_seq #(.DATA_W(DW), .CNT_W(16), .TMO_W(24)) dut (
    .clk(clk), .reset(reset),
    .avs_csr_address(addr), .avs_csr_write(wr), .avs_csr_writedata(wdata),
    .avs_csr_read(rd), .avs_csr_readdata(rdata),
    .src_start(src_start), .src_abort(src_abort),
    .cmp_err_valid(cmp_err_valid), .cmp_err_data(cmp_err_data), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_start) n_start <= n_start + 1;
    if (src_abort) n_abort <= n_abort + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic pulse_valid(input logic [DW-1:0] v);
    cmp_err_valid = 1'b1; cmp_err_data = v;
    @(negedge clk);
    cmp_err_valid = 1'b0; cmp_err_data = '0;
  endtask

  // Returns at the negedge where src_start is high (checks the current negedge first).
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (src_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("launch_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      csr_read(A_STS, s);
      if (!s[0]) begin ok = 1'b1; break; end
    end
    check("idle_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_run(input int n);
    int s0;
    bit ok;
    s0 = n_start;
    csr_write(A_NUM, 32'(n));
    csr_write(A_CTRL, 32'h5);
    for (int p = 0; p < n; p++) begin
      wait_start(ok);
      if (!ok) break;
      repeat (dly_arr[p]) @(negedge clk);
      pulse_valid(vec_arr[p]);
    end
    wait_idle();
    check("start_pulses", 32'(n_start - s0), 32'(n));
  endtask

  initial begin
    logic [31:0]   r;
    logic [DW-1:0] one, eacc;
    int            n, epass, efail, s0, a0, t0, t1;
    bit            ok, found;

    one = '0; one[0] = 1'b1;
    addr = '0; wr = 1'b0; wdata = '0; rd = 1'b0;
    cmp_err_valid = 1'b0; cmp_err_data = '0;
    reset = 1'b1;

    tv[0] = '{3, 8'h00, 0,   3, 0, 32'h2, 0, 32'h0};
    tv[1] = '{2, 8'h02, 37,  1, 1, 32'h6, 1, 32'h20};
    tv[2] = '{1, 8'h01, 127, 0, 1, 32'h6, 3, 32'h8000_0000};
    tv[3] = '{4, 8'h05, 64,  2, 2, 32'h6, 2, 32'h1};
    tv[4] = '{0, 8'h00, 0,   0, 0, 32'h2, 0, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", rdata, 32'h0);
    check("rst_outputs", {29'd0, irq, src_start, src_abort}, 32'h0);
    reset = 1'b0;
    csr_read(A_STS, r);  check("rst_status", r, 32'h0);
    csr_read(A_NUM, r);  check("rst_num_passes", r, 32'h0);
    csr_read(A_CTRL, r); check("rst_ctrl", r, 32'h0);

    // CTRL readback: b3 only exists with the optional feature
    csr_write(A_CTRL, 32'hC);
    csr_read(A_CTRL, r);
`ifdef AVST_COMPARE_SEQ_STOP_ON_FAIL_EN
    check("ctrl_readback", r, 32'hC);
`else
    check("ctrl_readback", r, 32'h4);
`endif

    // NUM_PASSES=0: done within two cycles, no launch
    s0 = n_start;
    csr_write(A_NUM, 32'h0);
    csr_write(A_CTRL, 32'h5);
    @(negedge clk);
    check("zero_pass_irq_t2", {31'd0, irq}, 32'd1);
    check("zero_pass_starts", 32'(n_start - s0), 32'd0);
    csr_read(A_PASS, r); check("zero_pass_pcnt", r, 32'd0);

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < 8; p++) begin
        vec_arr[p] = tv[i].fmask[p] ? (one << tv[i].bidx) : '0;
        dly_arr[p] = 1 + (p % 3);
      end
      do_run(tv[i].n);
      csr_read(A_PASS, r); check($sformatf("tbl%0d_pass_cnt", i), r, 32'(tv[i].exp_pass));
      csr_read(A_FAIL, r); check($sformatf("tbl%0d_fail_cnt", i), r, 32'(tv[i].exp_fail));
      csr_read(A_STS, r);  check($sformatf("tbl%0d_status", i), r, tv[i].exp_sts);
      check($sformatf("tbl%0d_irq", i), {31'd0, irq}, 32'd1);
      csr_write(A_SEL, 32'(tv[i].lane));
      csr_read(A_WORD, r); check($sformatf("tbl%0d_err_word", i), r, tv[i].exp_word);
    end

    // irq gating and W1C
    csr_write(A_CTRL, 32'h0);
    @(negedge clk);
    check("irq_disabled", {31'd0, irq}, 32'd0);
    csr_write(A_STS, 32'hE);
    csr_read(A_STS, r); check("w1c_clear", r, 32'h0);

    // Timeout: abort pulse 10 cycles after WAIT entry (11 after src_start)
    csr_write(A_TMO, 32'd10);
    csr_write(A_NUM, 32'd1);
    csr_write(A_CTRL, 32'h5);
    wait_start(ok);
    t0 = cyc; t1 = cyc; found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (src_abort) begin found = 1'b1; t1 = cyc; break; end
    end
    check("tmo_abort_delay", 32'(t1 - t0), 32'd11);
    @(negedge clk);
    check("tmo_abort_width", {31'd0, src_abort}, 32'd0);
    wait_idle();
    csr_read(A_STS, r);  check("tmo_status", r, 32'hE);
    csr_read(A_FAIL, r); check("tmo_fail_cnt", r, 32'd1);
    csr_read(A_PASS, r); check("tmo_pass_cnt", r, 32'd0);
    csr_write(A_TMO, 32'd0);

    // Abort in WAIT of pass 2 of 5
    s0 = n_start;
    csr_write(A_NUM, 32'd5);
    csr_write(A_CTRL, 32'h5);
    wait_start(ok);
    @(negedge clk);
    pulse_valid('0);
    wait_start(ok);
    a0 = n_abort;
    csr_write(A_CTRL, 32'h6);
    check("abort_pulse", {31'd0, src_abort}, 32'd1);
    @(negedge clk);
    check("abort_width", {31'd0, src_abort}, 32'd0);
    pulse_valid('1);
    wait_idle();
    csr_read(A_PASS, r); check("abort_pass_cnt", r, 32'd1);
    csr_read(A_FAIL, r); check("abort_fail_cnt", r, 32'd0);
    csr_read(A_STS, r);  check("abort_status", r, 32'h2);
    csr_write(A_SEL, 32'd0);
    csr_read(A_WORD, r); check("abort_late_valid_ignored", r, 32'h0);
    check("abort_count", 32'(n_abort - a0), 32'd1);
    check("abort_starts", 32'(n_start - s0), 32'd2);

    // Start while busy is ignored; W1C of done in the DONE cycle loses to the set
    s0 = n_start;
    csr_write(A_NUM, 32'd2);
    csr_write(A_CTRL, 32'h5);
    wait_start(ok);
    csr_write(A_CTRL, 32'h5);
    pulse_valid('0);
    wait_start(ok);
    @(negedge clk);
    pulse_valid('0);
    csr_write(A_STS, 32'h2);
    wait_idle();
    csr_read(A_STS, r);  check("w1c_vs_set_status", r, 32'h2);
    csr_read(A_PASS, r); check("busy_start_pass_cnt", r, 32'd2);
    check("busy_start_starts", 32'(n_start - s0), 32'd2);

    // Randomized runs against a pass/fail/OR model
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 6);
      epass = 0; efail = 0; eacc = '0;
      for (int p = 0; p < 8; p++) begin
        vec_arr[p] = '0;
        if ($urandom_range(0, 2) != 0) begin
          vec_arr[p][$urandom_range(0, DW-1)] = 1'b1;
          if ($urandom_range(0, 1) == 1) vec_arr[p][$urandom_range(0, DW-1)] = 1'b1;
        end
        dly_arr[p] = $urandom_range(1, 4);
      end
      for (int p = 0; p < n; p++) begin
        if (vec_arr[p] == '0) epass++; else efail++;
        eacc = eacc | vec_arr[p];
      end
      do_run(n);
      csr_read(A_PASS, r); check($sformatf("rnd%0d_pass_cnt", it), r, 32'(epass));
      csr_read(A_FAIL, r); check($sformatf("rnd%0d_fail_cnt", it), r, 32'(efail));
      csr_read(A_STS, r);  check($sformatf("rnd%0d_status", it), r, (efail != 0) ? 32'h6 : 32'h2);
      for (int l = 0; l < DW/32; l++) begin
        csr_write(A_SEL, 32'(l));
        csr_read(A_WORD, r);
        check($sformatf("rnd%0d_lane%0d", it, l), r, eacc[l*32 +: 32]);
      end
    end

    // Out-of-range lane reads zero
    csr_write(A_SEL, 32'd5);
    csr_read(A_SEL, r);  check("err_sel_readback", r, 32'd5);
    csr_read(A_WORD, r); check("err_word_out_of_range", r, 32'h0);

    // Reset mid-run: back to IDLE, no abort pulse, CSRs cleared
    csr_write(A_NUM, 32'd3);
    csr_write(A_CTRL, 32'h5);
    wait_start(ok);
    a0 = n_abort;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_abort", 32'(n_abort - a0), 32'd0);
    csr_read(A_STS, r); check("midrst_status", r, 32'h0);
    csr_read(A_NUM, r); check("midrst_num_passes", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
